// File: rtl/updown_count_monitor.sv
// updown_count_monitor
//
// Watches the q bus of an up/down counter and classifies each enabled step
// relative to the previous enabled sample as UP, DOWN, HOLD or ILLEGAL.
// After LOCK_N consecutive same-direction steps it locks onto that direction.
// While locked it reports direction reversals, holds and illegal steps, and
// it keeps a saturating count of illegal steps.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset, clears all state
//   en         sample qualifier; q_in is only evaluated when en=1
//   q_in       observed count value (WIDTH bits, wraps modulo 2^WIDTH)
//   locked     direction acquired and steps consistent
//   dir        locked direction, 1 = up, 0 = down
//   dir_chg    one-cycle pulse on a legal reversal while locked
//   hold       one-cycle pulse when an enabled sample repeats the previous one
//   step_err   one-cycle pulse on an illegal step while locked
//   err_count  saturating count of step_err events
//
// State table
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no reference sample yet; next enabled sample loads prev
//   ST_ACQUIRE | counting consecutive same-direction steps toward lock
//   ST_LOCKED  | direction known; reversals, holds and errors reported

module updown_count_monitor #(
  parameter int WIDTH     = 3,
  parameter int LOCK_N    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     q_in,
  output logic                 locked,
  output logic                 dir,
  output logic                 dir_chg,
  output logic                 hold,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STEP_HOLD    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  localparam logic [3:0]           LOCK_N_C = 4'(LOCK_N);
  localparam logic [WIDTH-1:0]     DELTA_UP = WIDTH'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic                 cand_dir_q, cand_dir_d;
  logic [3:0]           run_cnt_q, run_cnt_d;
  logic                 locked_q, locked_d;
  logic                 dir_q, dir_d;
  logic                 dir_chg_q, dir_chg_d;
  logic                 hold_q, hold_d;
  logic                 step_err_q, step_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0]     delta;
  step_t                step;
  logic                 step_dir;
  logic [3:0]           run_next;

  // Modular difference makes wrap-around (max->0 up, 0->max down) legal.
  always_comb begin
    delta = q_in - prev_q;
    if (delta == '0) begin
      step = STEP_HOLD;
    end else if (delta == DELTA_UP) begin
      step = STEP_UP;
    end else if (delta == '1) begin
      step = STEP_DOWN;
    end else begin
      step = STEP_ILLEGAL;
    end
    step_dir = (step == STEP_UP);
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    cand_dir_d  = cand_dir_q;
    run_cnt_d   = run_cnt_q;
    locked_d    = locked_q;
    dir_d       = dir_q;
    dir_chg_d   = 1'b0;
    hold_d      = 1'b0;
    step_err_d  = 1'b0;
    err_count_d = err_count_q;
    run_next    = run_cnt_q;

    if (en) begin
      prev_d = q_in;
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_ACQUIRE;
          run_cnt_d = 4'd0;
        end

        ST_ACQUIRE: begin
          case (step)
            STEP_UP, STEP_DOWN: begin
              // A zero run accepts either direction; a reversal restarts the
              // run at one because the reversing step itself is consistent.
              if ((run_cnt_q == 4'd0) || (step_dir == cand_dir_q)) begin
                run_next = run_cnt_q + 4'd1;
              end else begin
                run_next = 4'd1;
              end
              cand_dir_d = step_dir;
              if (run_next == LOCK_N_C) begin
                state_d   = ST_LOCKED;
                locked_d  = 1'b1;
                dir_d     = step_dir;
                run_cnt_d = 4'd0;
              end else begin
                run_cnt_d = run_next;
              end
            end
            STEP_HOLD: begin
              hold_d = 1'b1;
            end
            STEP_ILLEGAL: begin
              run_cnt_d = 4'd0;
            end
            default: begin
              run_cnt_d = 4'd0;
            end
          endcase
        end

        ST_LOCKED: begin
          case (step)
            STEP_UP, STEP_DOWN: begin
              if (step_dir != dir_q) begin
                dir_d     = step_dir;
                dir_chg_d = 1'b1;
              end
            end
            STEP_HOLD: begin
              hold_d = 1'b1;
            end
            STEP_ILLEGAL: begin
              // dir is kept so software can still see the last direction.
              step_err_d = 1'b1;
              if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + 1'b1;
              end
              state_d   = ST_ACQUIRE;
              run_cnt_d = 4'd0;
              locked_d  = 1'b0;
            end
            default: begin
              state_d = ST_ACQUIRE;
            end
          endcase
        end

        default: begin
          state_d   = ST_IDLE;
          run_cnt_d = 4'd0;
          locked_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      cand_dir_q  <= 1'b0;
      run_cnt_q   <= 4'd0;
      locked_q    <= 1'b0;
      dir_q       <= 1'b0;
      dir_chg_q   <= 1'b0;
      hold_q      <= 1'b0;
      step_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cand_dir_q  <= cand_dir_d;
      run_cnt_q   <= run_cnt_d;
      locked_q    <= locked_d;
      dir_q       <= dir_d;
      dir_chg_q   <= dir_chg_d;
      hold_q      <= hold_d;
      step_err_q  <= step_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign dir       = dir_q;
  assign dir_chg   = dir_chg_q;
  assign hold      = hold_q;
  assign step_err  = step_err_q;
  assign err_count = err_count_q;

endmodule

// File: doc/updown_count_monitor.md
# updown_count_monitor

Receive-side companion to the team's 3-bit up/down synchronous counter. It samples a counter's `q` bus each enabled clock and classifies every step as up, down, hold or illegal. It then locks onto the counting direction, reports direction changes and counts illegal steps. It sits on the observing end of any counter output, for example a bus-integrity checker in self-test logic. In the design, `dir` uses the same encoding as the counter's `mode` input: 1 means up, 0 means down.

## Interface
- `WIDTH`, default 3: width of the observed count bus; the count wraps modulo 2^WIDTH.
- `LOCK_N`, default 4: number of consecutive same-direction steps required to lock; legal range is 1 to 15.
- `ERR_CNT_W`, default 8: width of the saturating illegal-step counter.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low; clears all state immediately.
- `en`  input  1  sample qualifier; `q_in` is evaluated only on edges where `en`=1.
- `q_in`  input  WIDTH  observed count value.
- `locked`  output  1  direction acquired and steps are consistent.
- `dir`  output  1  locked direction; 1 = up, 0 = down.
- `dir_chg`  output  1  one-cycle pulse on a legal direction reversal while locked.
- `hold`  output  1  one-cycle pulse when an enabled sample equals the previous one.
- `step_err`  output  1  one-cycle pulse on an illegal step while locked.
- `err_count`  output  ERR_CNT_W  count of `step_err` events; saturates at all-ones.

## Operation
- Registers:
  - `prev` (WIDTH bits)
  - `cand_dir`
  - `run_cnt` (4 bits)
  - FSM state
  - all outputs
- Step classification, with delta = (`q_in` − `prev`) mod 2^WIDTH:
  - delta = 1 → UP
  - delta = all-ones → DOWN
  - delta = 0 → HOLD
  - any other delta → ILLEGAL
- FSM states: IDLE, ACQUIRE, LOCKED. All transitions happen only on enabled edges.
- IDLE:
  - The first enabled sample loads `prev` with no classification.
  - Next state is ACQUIRE, with `run_cnt`=0.
- ACQUIRE:
  - UP/DOWN equal to `cand_dir`, or with `run_cnt`=0: `cand_dir` takes that direction and `run_cnt` increments. When `run_cnt` reaches `LOCK_N`, the FSM goes to LOCKED, sets `dir`=`cand_dir`, asserts `locked`, and clears `run_cnt`.
  - UP/DOWN opposite to `cand_dir`: `run_cnt`=1 and `cand_dir` takes the new direction.
  - HOLD: `hold` pulses; `run_cnt` is unchanged.
  - ILLEGAL: `run_cnt`=0. There is no `step_err` and no count change.
- LOCKED:
  - Step equal to `dir`: no event.
  - Step opposite to `dir`: `dir` inverts, `dir_chg` pulses, `locked` stays 1.
  - HOLD: `hold` pulses; the FSM stays in LOCKED.
  - ILLEGAL: `step_err` pulses and `err_count` increments unless saturated. The FSM goes to ACQUIRE with `run_cnt`=0 and `locked`=0; `dir` keeps its last value.
- `prev` loads `q_in` on every enabled edge, in every state.
- `en`=0: all registers hold. Pulse outputs are 0 on that cycle. The next enabled sample is compared against the last enabled sample.
- Reset (`reset`=0), asynchronous and valid at any time including mid-lock: the state goes to IDLE and `prev`, `cand_dir`, `run_cnt` clear to 0. Every output resets to 0: `locked`, `dir`, `dir_chg`, `hold`, `step_err`, `err_count`.

## Timing
- All outputs are registered. An event caused by the sample at edge k is visible right after edge k and lasts exactly one cycle for the pulses.
- Lock latency is 1 + `LOCK_N` enabled edges from the first sample after IDLE; `locked` rises on the edge of the `LOCK_N`-th consistent step.
- There is no combinational path from any input to any output.
- Wrap-around is legal in both directions (7→0 is UP, 0→7 is DOWN for WIDTH=3).
- At most one of `dir_chg`, `hold`, `step_err` is asserted on any cycle.

## Test plan
- Acquire up:
  - Stimulus: reset, then `en`=1 with `q_in`=0,1,2,3,4 on successive edges.
  - Required: `locked`=1 and `dir`=1 after the edge sampling 4; no pulses; `err_count`=0.
- Wrap and lock down:
  - Stimulus: while locked up, apply 6,7,0,1 and confirm no errors; then apply 0,7,6,5.
  - Required: `dir_chg` pulses once at the sample 0 that follows 1; `dir`=0; `locked` stays 1; `err_count`=0.
- Illegal step:
  - Stimulus: locked up at 5, apply 7.
  - Required: one-cycle `step_err`, `err_count`=1, `locked`=0.
  - Follow-up: then apply 0,1,2,3; required `locked`=1 after the sample 3.
- Hold and enable gaps:
  - Stimulus: locked up at 3; apply 3 with `en`=1; then `en`=0 for 5 cycles while `q_in`=6; then `en`=1 with `q_in`=4.
  - Required: the sample 3 gives a `hold` pulse; the gap cycles give no events; the sample 4 is classified UP with no error.
- Saturation:
  - Stimulus: 260 illegal steps, each preceded by a re-lock, with `ERR_CNT_W`=8.
  - Required: `err_count` stops at 255.
- Reset mid-lock:
  - Stimulus: assert `reset`=0 asynchronously between edges while `locked`=1 and `err_count`=3.
  - Required: all outputs 0 before the next edge; after release the FSM is in IDLE and needs 1 + `LOCK_N` samples to re-lock.
